// File: rtl/inst_split_queue_pkg.sv
// Shared MIPS32 instruction field widths and opcode constants for the fetch/decode queue.
package inst_split_queue_pkg;

  localparam int OP_BUS      = 6;
  localparam int FUNC_BUS    = 6;
  localparam int Target_BUS  = 26;
  localparam int Shamt_BUS   = 5;
  localparam int Imm_BUS     = 16;
  localparam int RegAddr_BUS = 5;
  localparam int Inst_BUS    = 32;

  localparam logic [OP_BUS-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_BUS-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OP_BUS-1:0] OP_ORI     = 6'h0D;
  localparam logic [OP_BUS-1:0] OP_XORI    = 6'h0E;
  localparam logic [OP_BUS-1:0] OP_LUI     = 6'h0F;

  // Logical immediates zero-extend, LUI shifts into the upper half, all else sign-extends.
  function automatic logic [31:0] ext_imm(input logic [OP_BUS-1:0] op,
                                          input logic [Imm_BUS-1:0] imm);
    logic [31:0] r;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: r = {16'h0, imm};
      OP_LUI:                   r = {imm, 16'h0};
      default:                  r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_split_queue_field_slice.sv
// Combinational splitter of the queue head word into decode fields, zeroed when the head is empty.
// Optional imm_ext output is built only when INST_SPLIT_IMM_EXT_EN is defined.
module inst_field_slice
  import inst_split_queue_pkg::*;
(
  input  logic [Inst_BUS-1:0]    inst,
  input  logic                   valid,
  output logic [OP_BUS-1:0]      op,
  output logic [FUNC_BUS-1:0]    func,
  output logic [Target_BUS-1:0]  target,
  output logic [Shamt_BUS-1:0]   shamt,
  output logic [Imm_BUS-1:0]     imm_offset,
  output logic [RegAddr_BUS-1:0] rs,
  output logic [RegAddr_BUS-1:0] rt,
  output logic [RegAddr_BUS-1:0] rd,
  output logic                   is_rtype
`ifdef INST_SPLIT_IMM_EXT_EN
  ,output logic [31:0]           imm_ext
`endif
);

  logic [Inst_BUS-1:0] word;

  assign word       = valid ? inst : '0;
  assign op         = word[31:26];
  assign func       = word[5:0];
  assign target     = word[25:0];
  assign shamt      = word[10:6];
  assign imm_offset = word[15:0];
  assign rs         = word[25:21];
  assign rt         = word[20:16];
  assign rd         = word[15:11];
  assign is_rtype   = valid && (word[31:26] == OP_SPECIAL);

`ifdef INST_SPLIT_IMM_EXT_EN
  assign imm_ext = valid ? ext_imm(word[31:26], word[15:0]) : 32'h0;
`endif

endmodule

// File: rtl/inst_split_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {inst, pc} with valid/ready on both sides.
// Define INST_SPLIT_IMM_EXT_EN to add the extended-immediate output imm_ext.
module inst_split_queue
  import inst_split_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Inst_BUS-1:0]       in_inst,
  input  logic [PC_W-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W-1:0]           out_pc,
  output logic [OP_BUS-1:0]         op,
  output logic [FUNC_BUS-1:0]       func,
  output logic [Target_BUS-1:0]     target,
  output logic [Shamt_BUS-1:0]      shamt,
  output logic [Imm_BUS-1:0]        imm_offset,
  output logic [RegAddr_BUS-1:0]    rs,
  output logic [RegAddr_BUS-1:0]    rt,
  output logic [RegAddr_BUS-1:0]    rd,
  output logic                      is_rtype,
  output logic [$clog2(DEPTH):0]    count
`ifdef INST_SPLIT_IMM_EXT_EN
  ,output logic [31:0]              imm_ext
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [Inst_BUS-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]     mem_pc   [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                push;
  logic                pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; flush and reset only rewind the pointers.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  assign out_pc = out_valid ? mem_pc[rd_ptr] : '0;

  inst_field_slice u_slice (
    .inst       (mem_inst[rd_ptr]),
    .valid      (out_valid),
    .op         (op),
    .func       (func),
    .target     (target),
    .shamt      (shamt),
    .imm_offset (imm_offset),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .is_rtype   (is_rtype)
`ifdef INST_SPLIT_IMM_EXT_EN
    ,.imm_ext   (imm_ext)
`endif
  );

endmodule

// File: tb/tb_inst_split_queue.sv
// Self-checking bench for inst_split_queue: directed vector table, hand sequences, random vs queue model.
module tb_inst_split_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [25:0] target;
  logic [4:0]  shamt;
  logic [15:0] imm_offset;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        is_rtype;
  logic [2:0]  count;
`ifdef INST_SPLIT_IMM_EXT_EN
  logic [31:0] imm_ext;
`endif

  inst_split_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .op         (op),
    .func       (func),
    .target     (target),
    .shamt      (shamt),
    .imm_offset (imm_offset),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .is_rtype   (is_rtype),
    .count      (count)
`ifdef INST_SPLIT_IMM_EXT_EN
    ,.imm_ext   (imm_ext)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [63:0] q [$];
  bit model_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the queue content itself; outputs are the MIPS field slices of the oldest entry.
  task automatic check_model();
    logic        v;
    logic [31:0] w;
    logic [31:0] p;
    v = (q.size() != 0);
    w = v ? q[0][63:32] : 32'h0;
    p = v ? q[0][31:0]  : 32'h0;
    chk("count",     count,      q.size());
    chk("in_ready",  in_ready,   q.size() != DEPTH);
    chk("out_valid", out_valid,  v);
    chk("out_pc",    out_pc,     p);
    chk("op",        op,         w[31:26]);
    chk("func",      func,       w[5:0]);
    chk("target",    target,     w[25:0]);
    chk("shamt",     shamt,      w[10:6]);
    chk("imm",       imm_offset, w[15:0]);
    chk("rs",        rs,         w[25:21]);
    chk("rt",        rt,         w[20:16]);
    chk("rd",        rd,         w[15:11]);
    chk("is_rtype",  is_rtype,   v && (w[31:26] == 6'd0));
`ifdef INST_SPLIT_IMM_EXT_EN
    begin
      logic [31:0] e;
      if (!v) e = 0;
      else if (w[31:26] >= 6'h0C && w[31:26] <= 6'h0E) e = w & 32'h0000FFFF;
      else if (w[31:26] == 6'h0F) e = w << 16;
      else e = 32'($signed(w[15:0]));
      chk("imm_ext", imm_ext, e);
    end
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic r, input logic f, input logic iv, input logic [31:0] inst,
                       input logic [31:0] pc, input logic ordy);
    bit do_push, do_pop;
    rst = r; flush = f; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
    if (model_ok) check_model();
    @(posedge clk);
    if (r || f) begin
      q.delete();
      model_ok = 1'b1;
    end else begin
      do_pop  = ordy && (q.size() != 0);
      do_push = iv && (q.size() != DEPTH);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({inst, pc});
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [31:0] inst, pc;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_head;
  } vec_t;

  vec_t vecs [14];

  task automatic reset_checks(input string tag);
    chk({tag, " count"},     count,     0);
    chk({tag, " in_ready"},  in_ready,  1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_pc"},    out_pc,    0);
    chk({tag, " fields"},    {op, func, target, shamt, imm_offset, rs, rt, rd, is_rtype}, 0);
`ifdef INST_SPLIT_IMM_EXT_EN
    chk({tag, " imm_ext"},   imm_ext,   0);
`endif
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0};
    vecs[1]  = '{0, 0, 1, 0, 32'h012A4020, 32'h00400000, 1, 1, 32'h00400000, 32'h012A4020};
    vecs[2]  = '{0, 0, 1, 0, 32'h3421FFFF, 32'h00400004, 2, 1, 32'h00400000, 32'h012A4020};
    vecs[3]  = '{0, 0, 1, 0, 32'h2021FFFF, 32'h00400008, 3, 1, 32'h00400000, 32'h012A4020};
    vecs[4]  = '{0, 0, 1, 0, 32'h3C011234, 32'h0040000C, 4, 1, 32'h00400000, 32'h012A4020};
    vecs[5]  = '{0, 0, 1, 0, 32'hDEADBEEF, 32'h00400010, 4, 1, 32'h00400000, 32'h012A4020};
    vecs[6]  = '{0, 0, 0, 1, 32'h0,        32'h0,        3, 1, 32'h00400004, 32'h3421FFFF};
    vecs[7]  = '{0, 0, 0, 1, 32'h0,        32'h0,        2, 1, 32'h00400008, 32'h2021FFFF};
    vecs[8]  = '{0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h0040000C, 32'h3C011234};
    vecs[9]  = '{0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0};
    vecs[10] = '{0, 0, 1, 1, 32'h8C220004, 32'h00400014, 1, 1, 32'h00400014, 32'h8C220004};
    vecs[11] = '{0, 0, 1, 0, 32'h00851825, 32'h00400018, 2, 1, 32'h00400014, 32'h8C220004};
    vecs[12] = '{0, 1, 1, 0, 32'hAC430008, 32'h0040001C, 0, 0, 32'h0,        32'h0};
    vecs[13] = '{0, 0, 1, 0, 32'h08100000, 32'h00400020, 1, 1, 32'h00400020, 32'h08100000};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      logic [31:0] h;
      cycle(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].inst, vecs[i].pc, vecs[i].ordy);
      h = vecs[i].exp_head;
      chk($sformatf("vec%0d count", i),     count,      vecs[i].exp_count);
      chk($sformatf("vec%0d out_valid", i), out_valid,  vecs[i].exp_valid);
      chk($sformatf("vec%0d out_pc", i),    out_pc,     vecs[i].exp_pc);
      chk($sformatf("vec%0d fields", i),    {op, rs, rt, rd, shamt, func},
          {h[31:26], h[25:21], h[20:16], h[15:11], h[10:6], h[5:0]});
      chk($sformatf("vec%0d is_rtype", i),  is_rtype,   vecs[i].exp_valid && h[31:26] == 6'd0);
      if (i == 12) reset_checks("flush");
    end

`ifdef INST_SPLIT_IMM_EXT_EN
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h3421FFFF, 32'h100, 0);
    chk("ext ori", imm_ext, 32'h0000FFFF);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h2021FFFF, 32'h104, 0);
    chk("ext addi", imm_ext, 32'hFFFFFFFF);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h3C011234, 32'h108, 0);
    chk("ext lui", imm_ext, 32'h12340000);
`endif

    // Sustained push+pop at count 2 across several pointer wraps.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h00000020, 32'h200, 0);
    cycle(0, 0, 1, 32'h00000021, 32'h204, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 32'h00000022 + i, 32'h208 + 4 * i, 1);
      chk("thru count", count, 2);
      chk("thru head pc", out_pc, 32'h200 + 4 * (i + 1));
    end

    // Reset overriding flush with three entries queued, then reset again from idle.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h11111111, 32'h300, 0);
    cycle(0, 0, 1, 32'h22222222, 32'h304, 0);
    cycle(0, 0, 1, 32'h33333333, 32'h308, 0);
    chk("pre-rst count", count, 3);
    cycle(1, 1, 1, 32'h44444444, 32'h30C, 1);
    reset_checks("rst busy");
    cycle(1, 0, 0, 0, 0, 0);
    reset_checks("rst idle");
    cycle(0, 0, 1, 32'h55555555, 32'h310, 0);
    chk("post-rst pc", out_pc, 32'h310);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      logic [1:0]  sel;
      w = $urandom;
      sel = 2'($urandom_range(0, 3));
      if (sel == 0) w[31:26] = 6'd0;
      else if (sel == 1) w[31:26] = 6'(6'h0C + $urandom_range(0, 3));
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 70, w, $urandom, $urandom_range(0, 99) < 60);
    end
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_split_queue.md
# inst_split_queue

Parametrised instruction queue and field splitter sitting between instruction fetch and decode in the MIPS32 pipeline. It buffers up to DEPTH fetched instruction/PC pairs behind a valid/ready handshake. It presents the head entry already split into op, func, target, shamt, immediate and register-address fields. A synchronous flush discards queued entries on a branch or jump redirect.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- PC_W, 32: width of the PC carried alongside each instruction
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all queued entries this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue accepts an instruction this cycle
- in_inst  in  32  instruction word (`Inst_BUS`)
- in_pc  in  PC_W  PC of in_inst
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  PC_W  PC of head entry
- op  out  6  inst[31:26]
- func  out  6  inst[5:0]
- target  out  26  inst[25:0]
- shamt  out  5  inst[10:6]
- imm_offset  out  16  inst[15:0]
- rs / rt / rd  out  5 each  inst[25:21] / inst[20:16] / inst[15:11]
- is_rtype  out  1  op == 6'h00
- count  out  $clog2(DEPTH)+1  occupied entries
- imm_ext  out  32  extended immediate; present only with INST_SPLIT_IMM_EXT_EN

## Operation
- Circular buffer: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap DEPTH-1→0), count 0..DEPTH.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); no write-through when full, even if popping the same cycle.
- out_valid = (count != 0).
- push only: store {in_inst,in_pc} at wr_ptr, wr_ptr+1, count+1. Pop only: rd_ptr+1, count-1. Both: both pointers advance, count unchanged.
- Field outputs are combinational slices of the head entry; all field outputs, is_rtype and out_pc are forced to 0 while out_valid=0.
- flush: wr_ptr, rd_ptr, count ← 0 next edge; a push or pop in the same cycle is ignored. Data storage is not cleared.
- rst: same effect as flush; rst takes priority over flush.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, every field output, out_pc and imm_ext = 0.
- Latency: instruction pushed at edge N is visible on outputs after edge N (cycle N+1) when the queue was empty.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Full: in_ready=0 in the cycle count==DEPTH; rises the cycle after a pop.
- Empty with push+out_ready same cycle: no pop occurs (out_valid=0); entry appears next cycle.
- Flush/reset mid-stream: out_valid=0 and in_ready=1 on the next cycle; the first post-flush push is stored at entry 0.
- Handshake: in_inst/in_pc sampled only on push; upstream holds data while in_valid & !in_ready.

## Configuration
- INST_SPLIT_IMM_EXT_EN defined: imm_ext port exists. imm_ext = {16'h0, imm} for op 6'h0C/6'h0D/6'h0E (ANDI/ORI/XORI). imm_ext = {imm, 16'h0} for op 6'h0F (LUI). imm_ext = {{16{imm[15]}}, imm} otherwise. Forced to 0 while out_valid=0.
- Undefined: no imm_ext port and no extension logic; all other behaviour identical.

## Structure
- Shared definitions file: field bus widths (`OP_BUS`, `FUNC_BUS`, `Target_BUS`, `Shamt_BUS`, `Imm_BUS`, `RegAddr_BUS`, `Inst_BUS`) and the opcode constants ANDI/ORI/XORI/LUI.
- One sub-module: inst_field_slice, purely combinational; takes the head word plus out_valid and produces the gated fields, is_rtype and imm_ext.
- Storage, pointers and count live in the top module.

## Test plan
- Reset, then push 32'h012A4020 at PC 32'h00400000 → next cycle: out_valid=1, op=0, rs=9, rt=10, rd=8, func=6'h20, is_rtype=1, count=1.
- Push DEPTH=4 words with out_ready=0 → in_ready=0 at count=4; a fifth in_valid is not stored; then pop all 4 → PCs emerge in push order.
- Keep count=2 and assert push+pop every cycle for 10 cycles → count stays 2, pointers wrap, and the output order matches the input order.
- Two entries queued; flush together with in_valid=1 → next cycle count=0, out_valid=0, all fields 0; the following push is visible with count=1.
- With INST_SPLIT_IMM_EXT_EN: head 32'h3421FFFF (ORI) → imm_ext=32'h0000FFFF; head 32'h2021FFFF (ADDI) → imm_ext=32'hFFFFFFFF; head 32'h3C011234 (LUI) → imm_ext=32'h12340000.
- Assert rst while 3 entries are queued and flush=1 → next cycle matches the reset values; the reset sequence is repeated from idle.
